// File: rtl/button_debouncer.sv
// Per-bit button debouncer: shared sample timer plus a saturating high-sample counter per bit.
// Define BUTTON_DEBOUNCER_EDGE_EN to compile in the one-cycle rising-edge pulse on edge_pulse.
module button_debouncer #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] edge_pulse
);

    localparam int SW = $clog2(SAMPLE_CNT_MAX);
    localparam int PW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
    localparam logic [PW-1:0] PULSE_FULL  = PW'(PULSE_CNT_MAX);

    logic [SW-1:0] sample_cnt;
    logic          sample_pulse;
    logic [PW-1:0] sat_cnt [WIDTH];

    // Sample timer: one pulse per period, shared by every bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (sample_cnt == SAMPLE_LAST) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + SW'(1);
        end
    end

    assign sample_pulse = (sample_cnt == SAMPLE_LAST);

    // A low input clears immediately, even on a sample cycle
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (!rst_n) begin
                sat_cnt[i] <= '0;
            end else if (!glitchy_signal[i]) begin
                sat_cnt[i] <= '0;
            end else if (sample_pulse && (sat_cnt[i] < PULSE_FULL)) begin
                sat_cnt[i] <= sat_cnt[i] + PW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            debounced_signal[i] = (sat_cnt[i] == PULSE_FULL);
        end
    end

`ifdef BUTTON_DEBOUNCER_EDGE_EN
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= '0;
        end else begin
            prev <= debounced_signal;
        end
    end

    assign edge_pulse = debounced_signal & ~prev;
`else
    assign edge_pulse = {WIDTH{1'b0}};
`endif

endmodule
